// File: rtl/data_mem_ctl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctl
// Purpose  : Single-port W x 2^A data memory with registered reads, a
//            read-valid strobe, a zero-fill clear engine (after reset and/or
//            on request) and a sticky error flag for accesses dropped while
//            the clear engine is busy.
// Options  : DATA_MEM_BYPASS_EN - when defined, a same-cycle write+read
//            returns the write data (write-first); otherwise read-first.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_ctl #(
    parameter int W             = 8,
    parameter int A             = 8,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] dat_in,
    input  logic         wr_en,
    input  logic         rd_en,
    input  logic [A-1:0] addr,
    input  logic         clr_req,
    output logic [W-1:0] dat_out,
    output logic         rd_valid,
    output logic         busy,
    output logic         err
);

    localparam int DEPTH = 1 << A;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t         state;
    logic [A-1:0]   cptr;
    logic [W-1:0]   mem [0:DEPTH-1];

    // The engine owns the array while sweeping; busy is a pure decode of state
    assign busy = (state == CLEAR);

    // Array write port: sweep writes zeros, otherwise accepted host writes.
    // Reset edges never touch the array, so a mid-sweep reset leaves the
    // partially cleared contents as they are.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[cptr] <= '0;
            end else if (wr_en) begin
                mem[addr] <= dat_in;
            end
        end
    end

    // Control FSM with registered read data, read strobe, pointer and error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT_ON_RESET ? CLEAR : IDLE;
            cptr     <= '0;
            dat_out  <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A clear request still lets this cycle's access through
                    if (clr_req) begin
                        state <= CLEAR;
                        cptr  <= '0;
                    end
                    if (rd_en) begin
`ifdef DATA_MEM_BYPASS_EN
                        // Single address port, so a concurrent write always
                        // targets the word being read: forward its data.
                        if (wr_en) begin
                            dat_out <= dat_in;
                        end else begin
                            dat_out <= mem[addr];
                        end
`else
                        // Non-blocking array update makes this read-first
                        dat_out <= mem[addr];
`endif
                        rd_valid <= 1'b1;
                    end else begin
                        rd_valid <= 1'b0;
                    end
                end
                CLEAR: begin
                    // Host accesses are dropped and flagged; clr_req ignored
                    rd_valid <= 1'b0;
                    if (wr_en || rd_en) begin
                        err <= 1'b1;
                    end
                    cptr <= cptr + A'(1);
                    if (cptr == {A{1'b1}}) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    rd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_ctl
// Purpose  : Directed self-checking bench for data_mem_ctl (default 8x256
//            instance plus a 16x16 instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  dat_in;
    logic        wr_en, rd_en, clr_req;
    logic [7:0]  addr;
    logic [7:0]  dat_out;
    logic        rd_valid, busy, err;

    logic        reset2;
    logic [15:0] dat_in2;
    logic        wr_en2, rd_en2, clr_req2;
    logic [3:0]  addr2;
    logic [15:0] dat_out2;
    logic        rd_valid2, busy2, err2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_ctl #(.W(8), .A(8), .INIT_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset), .dat_in(dat_in), .wr_en(wr_en),
        .rd_en(rd_en), .addr(addr), .clr_req(clr_req), .dat_out(dat_out),
        .rd_valid(rd_valid), .busy(busy), .err(err)
    );

    data_mem_ctl #(.W(16), .A(4), .INIT_ON_RESET(1'b1)) dut_small (
        .clk(clk), .reset(reset2), .dat_in(dat_in2), .wr_en(wr_en2),
        .rd_en(rd_en2), .addr(addr2), .clr_req(clr_req2), .dat_out(dat_out2),
        .rd_valid(rd_valid2), .busy(busy2), .err(err2)
    );

    // Advance one cycle; outputs are observed 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        addr = a; dat_in = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    // Count cycles until busy falls; cap keeps the bench from hanging
    task automatic count_busy(inout int n);
        while (busy && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        checks++;
        if (dat_out !== 8'h00 || rd_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: dat_out=%h rd_valid=%b err=%b busy=%b, want 00/0/0/1",
                     dat_out, rd_valid, err, busy);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_init_sweep();
        int n = 0;
        logic [7:0] rd_addrs [3];
        rd_addrs[0] = 8'h00; rd_addrs[1] = 8'h7F; rd_addrs[2] = 8'hFF;
        count_busy(n);
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL init_sweep_len: busy cycles=%0d, want 256", n);
        end
        for (int i = 0; i < 3; i++) begin
            addr = rd_addrs[i]; rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            checks++;
            if (dat_out !== 8'h00 || rd_valid !== 1'b1) begin
                errors++;
                $display("FAIL init_read_%h: dat_out=%h rd_valid=%b, want 00/1",
                         rd_addrs[i], dat_out, rd_valid);
            end
        end
    endtask

    task automatic test_write_read();
        do_write(8'h10, 8'hA5);
        addr = 8'h10; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (dat_out !== 8'hA5 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL wr_rd: dat_out=%h rd_valid=%b, want a5/1", dat_out, rd_valid);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (dat_out !== 8'hA5 || rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL wr_rd_hold%0d: dat_out=%h rd_valid=%b, want a5/0",
                         i, dat_out, rd_valid);
            end
        end
    endtask

    task automatic test_same_cycle_rw();
        logic [7:0] exp;
`ifdef DATA_MEM_BYPASS_EN
        exp = 8'h5A;
`else
        exp = 8'h3C;
`endif
        do_write(8'h20, 8'h3C);
        addr = 8'h20; dat_in = 8'h5A; wr_en = 1'b1; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        checks++;
        if (dat_out !== exp || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_rw: dat_out=%h rd_valid=%b, want %h/1", dat_out, rd_valid, exp);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (dat_out !== 8'h5A) begin
            errors++;
            $display("FAIL same_cycle_rw_later: dat_out=%h, want 5a", dat_out);
        end
    endtask

    task automatic test_clear_err();
        int n = 0;
        logic [7:0] chk_addrs [3];
        chk_addrs[0] = 8'h40; chk_addrs[1] = 8'h00; chk_addrs[2] = 8'hFF;
        do_write(8'h40, 8'hFF);
        do_write(8'h00, 8'h22);
        do_write(8'hFF, 8'h11);
        // Leave a known nonzero value on dat_out to see it hold through the sweep
        addr = 8'h40; rd_en = 1'b1; clr_req = 1'b1;
        tick();
        rd_en = 1'b0; clr_req = 1'b0;
        checks++;
        if (busy !== 1'b1 || dat_out !== 8'hFF || rd_valid !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL clr_start: busy=%b dat_out=%h rd_valid=%b err=%b, want 1/ff/1/0",
                     busy, dat_out, rd_valid, err);
        end
        for (int i = 0; i < 9; i++) begin
            tick();
            n++;
        end
        do_write(8'h40, 8'h99);
        n++;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: err=%b, want 1", err);
        end
        addr = 8'h01; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n++;
        checks++;
        if (rd_valid !== 1'b0 || dat_out !== 8'hFF) begin
            errors++;
            $display("FAIL dropped_read: rd_valid=%b dat_out=%h, want 0/ff", rd_valid, dat_out);
        end
        count_busy(n);
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL clr_sweep_len: busy cycles=%0d, want 256", n);
        end
        for (int i = 0; i < 3; i++) begin
            addr = chk_addrs[i]; rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            checks++;
            if (dat_out !== 8'h00 || rd_valid !== 1'b1 || err !== 1'b1) begin
                errors++;
                $display("FAIL cleared_%h: dat_out=%h rd_valid=%b err=%b, want 00/1/1",
                         chk_addrs[i], dat_out, rd_valid, err);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n = 0;
        do_write(8'h05, 8'h77);
        addr = 8'h05; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 99; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b1 || err !== 1'b1 - 1'b1 || dat_out !== 8'h00 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b err=%b dat_out=%h rd_valid=%b, want 1/0/00/0",
                     busy, err, dat_out, rd_valid);
        end
        count_busy(n);
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL mid_reset_sweep_len: busy cycles=%0d, want 256", n);
        end
    endtask

    task automatic test_small_config();
        int n = 0;
        reset2 = 1'b1;
        tick();
        reset2 = 1'b0;
        while (busy2 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL small_sweep_len: busy cycles=%0d, want 16", n);
        end
        addr2 = 4'hF; dat_in2 = 16'hBEEF; wr_en2 = 1'b1;
        tick();
        wr_en2 = 1'b0; rd_en2 = 1'b1;
        tick();
        rd_en2 = 1'b0;
        checks++;
        if (dat_out2 !== 16'hBEEF || rd_valid2 !== 1'b1) begin
            errors++;
            $display("FAIL small_rd: dat_out=%h rd_valid=%b, want beef/1", dat_out2, rd_valid2);
        end
    endtask

    initial begin
        reset = 1'b1; dat_in = '0; wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0; addr = '0;
        reset2 = 1'b1; dat_in2 = '0; wr_en2 = 1'b0; rd_en2 = 1'b0; clr_req2 = 1'b0; addr2 = '0;
        test_reset();
        test_init_sweep();
        test_write_read();
        test_same_cycle_rw();
        test_clear_err();
        test_reset_mid_sweep();
        test_small_config();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
